// File: rtl/gpio_filter_pkg.sv
// Shared defaults for the GPIO input conditioning stage.
package gpio_filter_pkg;

    localparam int unsigned GPIO_WIDTH       = 32;
    localparam int unsigned GPIO_SYNC_STAGES = 2;
    localparam int unsigned GPIO_PRESCALE_W  = 16;
    localparam int unsigned GPIO_CNT_W       = 4;

endpackage

// File: rtl/gpio_input_filter_if.sv
// Pad-side inputs, filter configuration and conditioned outputs of gpio_input_filter.
interface gpio_input_filter_if
    import gpio_filter_pkg::*;
#(
    parameter int unsigned WIDTH      = GPIO_WIDTH,
    parameter int unsigned PRESCALE_W = GPIO_PRESCALE_W,
    parameter int unsigned CNT_W      = GPIO_CNT_W
);

    logic [WIDTH-1:0]      pad_i;
    logic                  cfg_enable_i;
    logic [PRESCALE_W-1:0] cfg_prescale_i;
    logic [CNT_W-1:0]      cfg_threshold_i;
    logic [WIDTH-1:0]      cfg_bypass_i;
    logic [WIDTH-1:0]      gpio_input_o;
    logic [WIDTH-1:0]      rise_o;
    logic [WIDTH-1:0]      fall_o;
    logic                  tick_o;

    // Side that drives pads and configuration.
    modport master (
        output pad_i,
        output cfg_enable_i,
        output cfg_prescale_i,
        output cfg_threshold_i,
        output cfg_bypass_i,
        input  gpio_input_o,
        input  rise_o,
        input  fall_o,
        input  tick_o
    );

    // The filter itself.
    modport slave (
        input  pad_i,
        input  cfg_enable_i,
        input  cfg_prescale_i,
        input  cfg_threshold_i,
        input  cfg_bypass_i,
        output gpio_input_o,
        output rise_o,
        output fall_o,
        output tick_o
    );

endinterface

// File: rtl/gpio_filter_bit.sv
// One pin: synchroniser chain, stability counter, filtered level and edge pulses.
module gpio_filter_bit
    import gpio_filter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int unsigned CNT_W       = GPIO_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pad_i,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic             bypass_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             filt_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W:0]         thr_eff;
    logic [CNT_W:0]         cnt_inc;

    // Shift the pad into the synchroniser; the last stage is the only one the filter sees.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        sync   = sync_q[SYNC_STAGES-1];
    end

    // Debounce next state: a change is accepted after thr ticks with sync != filt.
    always_comb begin
        // A threshold of 0 behaves like 1 so a pin can never lock up.
        thr_eff = (thr_i == '0) ? (CNT_W + 1)'(1) : {1'b0, thr_i};
        cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        if (bypass_i) begin
            filt_d = sync;
            cnt_d  = '0;
        end else if (!enable_i) begin
            filt_d = filt_q;
            cnt_d  = cnt_q;
        end else if (sync == filt_q) begin
            // Any return to the filtered level restarts the count.
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_inc >= thr_eff) begin
                filt_d = sync;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
        rise_d = ~filt_q & filt_d;
        fall_d = filt_q & ~filt_d;
    end

    // Pin state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO input conditioning: shared sample prescaler plus WIDTH debounced pins.
module gpio_input_filter
    import gpio_filter_pkg::*;
#(
    parameter int unsigned WIDTH       = GPIO_WIDTH,
    parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int unsigned PRESCALE_W  = GPIO_PRESCALE_W,
    parameter int unsigned CNT_W       = GPIO_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    gpio_input_filter_if.slave bus
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick;
    logic                  tick_q;
    logic [WIDTH-1:0]      filt;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      fall;

    // Prescaler: >= rather than == so shrinking the period mid-count ticks at once.
    always_comb begin
        tick   = bus.cfg_enable_i && (pcnt_q >= bus.cfg_prescale_i);
        pcnt_d = pcnt_q + PRESCALE_W'(1);
        if (!bus.cfg_enable_i || tick) begin
            pcnt_d = '0;
        end
    end

    // Prescaler count and the registered copy of tick exported for observability.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_filter_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .pad_i    (bus.pad_i[i]),
            .tick_i   (tick),
            .enable_i (bus.cfg_enable_i),
            .bypass_i (bus.cfg_bypass_i[i]),
            .thr_i    (bus.cfg_threshold_i),
            .filt_o   (filt[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    assign bus.gpio_input_o = filt;
    assign bus.rise_o       = rise;
    assign bus.fall_o       = fall;
    assign bus.tick_o       = tick_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Self-checking bench for gpio_input_filter: vector table, directed corner cases, random vs model.
module tb_gpio_input_filter;
    import gpio_filter_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned SS = 2;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_input_filter_if #(.WIDTH(W), .PRESCALE_W(PW), .CNT_W(CW)) bus ();

    gpio_input_filter #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .PRESCALE_W  (PW),
        .CNT_W       (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pad;
        logic [31:0] gpio;
        logic [31:0] rise;
        logic [31:0] fall;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge count %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        edge_n = 0;
    endtask

    // Step until gpio bit reaches val; reports the edge count and pulses seen on that bit.
    task automatic wait_level(input int bitn, input logic val, input int budget,
                              output int at, output int rises, output int falls);
        at = -1;
        rises = 0;
        falls = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            rises += int'(bus.rise_o[bitn]);
            falls += int'(bus.fall_o[bitn]);
            if (bus.gpio_input_o[bitn] === val) begin
                at = edge_n;
                break;
            end
        end
    endtask

    task automatic set_cfg(input logic en, input int p, input int thr, input logic [31:0] byp);
        bus.cfg_enable_i    = en;
        bus.cfg_prescale_i  = PW'(p);
        bus.cfg_threshold_i = CW'(thr);
        bus.cfg_bypass_i    = byp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [13];
        int          at, rises, falls;
        logic [31:0] acc_g, acc_r, acc_f;
        logic [31:0] pad;

        tbl[0]  = '{32'h5555_5555, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{32'h5555_5555, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[2]  = '{32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h0000_0000};
        tbl[3]  = '{32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 32'h0000_0000};
        tbl[4]  = '{32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 32'h0000_0000};
        tbl[5]  = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h5555_5555};
        tbl[6]  = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h0000_0000, 32'h0000_0000};
        tbl[7]  = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h0000_0000, 32'h0000_0000};
        tbl[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_0000};
        tbl[9]  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        tbl[11] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[12] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        // Reset state and bypass path (enable off: bypass must not depend on it).
        bus.pad_i = '0;
        set_cfg(1'b0, 0, 0, 32'hFFFF_FFFF);
        do_reset();
        check("reset_gpio", bus.gpio_input_o, 32'h0);
        check("reset_rise", bus.rise_o, 32'h0);
        check("reset_fall", bus.fall_o, 32'h0);
        check("reset_tick", {31'h0, bus.tick_o}, 32'h0);
        for (int i = 0; i < 13; i++) begin
            bus.pad_i = tbl[i].pad;
            step();
            check($sformatf("bypass_gpio[%0d]", i), bus.gpio_input_o, tbl[i].gpio);
            check($sformatf("bypass_rise[%0d]", i), bus.rise_o, tbl[i].rise);
            check($sformatf("bypass_fall[%0d]", i), bus.fall_o, tbl[i].fall);
        end

        // Debounce accept: P=3 thr=4, ticks at edges 3,7,11,15 -> level after 16 edges.
        bus.pad_i = '0;
        set_cfg(1'b1, 3, 4, 32'h0);
        do_reset();
        bus.pad_i = 32'h1;
        wait_level(0, 1'b1, 40, at, rises, falls);
        check("accept_edge", at, 16);
        check("accept_rise_count", rises, 1);
        check("accept_rise_with_level", {31'h0, bus.rise_o[0]}, 32'h1);
        step();
        check("accept_rise_single", bus.rise_o, 32'h0);
        check("accept_level_held", bus.gpio_input_o, 32'h1);

        // Glitch reject: 10 cycles high covers only 3 ticks.
        bus.pad_i = '0;
        do_reset();
        acc_g = '0;
        acc_r = '0;
        acc_f = '0;
        for (int i = 0; i < 30; i++) begin
            bus.pad_i = (i < 10) ? 32'h1 : 32'h0;
            step();
            acc_g |= bus.gpio_input_o;
            acc_r |= bus.rise_o;
            acc_f |= bus.fall_o;
        end
        check("glitch_gpio", acc_g, 32'h0);
        check("glitch_rise", acc_r, 32'h0);
        check("glitch_fall", acc_f, 32'h0);
        // Count must have restarted: a fresh step needs 4 full ticks (edges 35..47).
        bus.pad_i = 32'h1;
        wait_level(0, 1'b1, 40, at, rises, falls);
        check("glitch_fresh_accept_edge", at, 48);

        // Fall edge with threshold 0 and P=0.
        bus.pad_i = '0;
        set_cfg(1'b1, 0, 0, 32'h0);
        do_reset();
        bus.pad_i = 32'h80;
        repeat (5) step();
        check("fall_setup_level", bus.gpio_input_o, 32'h80);
        bus.pad_i = 32'h0;
        step();
        check("fall_edge5_level", bus.gpio_input_o, 32'h80);
        step();
        check("fall_edge6_level", bus.gpio_input_o, 32'h80);
        check("fall_edge6_fall", bus.fall_o, 32'h0);
        step();
        check("fall_edge7_level", bus.gpio_input_o, 32'h0);
        check("fall_edge7_fall", bus.fall_o, 32'h80);
        check("fall_edge7_rise", bus.rise_o, 32'h0);
        step();
        check("fall_pulse_single", bus.fall_o, 32'h0);

        // Reset mid-count on pin 3: two ticks counted, then reset discards them.
        bus.pad_i = '0;
        set_cfg(1'b1, 3, 4, 32'h0);
        do_reset();
        bus.pad_i = 32'h8;
        repeat (9) step();
        check("midrst_pre_level", bus.gpio_input_o, 32'h0);
        do_reset();
        check("midrst_gpio", bus.gpio_input_o, 32'h0);
        check("midrst_rise", bus.rise_o, 32'h0);
        check("midrst_fall", bus.fall_o, 32'h0);
        check("midrst_tick", {31'h0, bus.tick_o}, 32'h0);
        wait_level(3, 1'b1, 40, at, rises, falls);
        check("midrst_accept_edge", at, 16);

        // Prescale shrink at pcnt=10 (20 -> 5): tick at edge 10, then every 6.
        bus.pad_i = '0;
        set_cfg(1'b1, 20, 4, 32'h0);
        do_reset();
        for (int k = 0; k < 31; k++) begin
            if (k == 10) bus.cfg_prescale_i = PW'(5);
            step();
            check($sformatf("shrink_tick[%0d]", k), {31'h0, bus.tick_o},
                  {31'h0, (k == 10 || k == 16 || k == 22 || k == 28)});
        end
        // Disabled: even with P=0 and thr=1 nothing may tick or move.
        set_cfg(1'b0, 0, 1, 32'h0);
        for (int k = 0; k < 20; k++) begin
            bus.pad_i = $urandom;
            step();
            check($sformatf("disable_tick[%0d]", k), {31'h0, bus.tick_o}, 32'h0);
            check($sformatf("disable_gpio[%0d]", k), bus.gpio_input_o, 32'h0);
        end

        // Random traffic against a rule-level model.
        for (int r = 0; r < 8; r++) begin
            int          p, thr, thr_eff;
            logic [31:0] byp, m_filt, m_prev, sync;
            logic [31:0] hist [$];
            int          run [32];
            bit          tk;
            p   = $urandom_range(0, 3);
            thr = $urandom_range(0, 5);
            byp = $urandom & $urandom;
            thr_eff = (thr == 0) ? 1 : thr;
            set_cfg(1'b1, p, thr, byp);
            pad = $urandom;
            bus.pad_i = pad;
            do_reset();
            hist.delete();
            for (int s = 0; s < SS; s++) hist.push_back(32'h0);
            m_filt = '0;
            for (int i = 0; i < 32; i++) run[i] = 0;
            for (int k = 0; k < 200; k++) begin
                pad ^= ($urandom & $urandom & $urandom);
                bus.pad_i = pad;
                hist.push_back(pad);
                sync   = hist.pop_front();
                tk     = ((k % (p + 1)) == p);
                m_prev = m_filt;
                for (int i = 0; i < 32; i++) begin
                    if (byp[i]) begin
                        m_filt[i] = sync[i];
                        run[i]    = 0;
                    end else if (sync[i] == m_filt[i]) begin
                        run[i] = 0;
                    end else if (tk) begin
                        run[i]++;
                        if (run[i] >= thr_eff) begin
                            m_filt[i] = sync[i];
                            run[i]    = 0;
                        end
                    end
                end
                step();
                check($sformatf("rand%0d_gpio[%0d]", r, k), bus.gpio_input_o, m_filt);
                check($sformatf("rand%0d_rise[%0d]", r, k), bus.rise_o, ~m_prev & m_filt);
                check($sformatf("rand%0d_fall[%0d]", r, k), bus.fall_o, m_prev & ~m_filt);
                check($sformatf("rand%0d_tick[%0d]", r, k), {31'h0, bus.tick_o}, {31'h0, tk});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_input_filter.md
# gpio_input_filter

Input conditioning stage between the GPIO pads and the `gpio` block's `gpio_input_i` port. It synchronises each asynchronous pad input into `clk_i` and debounces it with a shared sample prescaler and a per-pin stability counter. It also flags filtered rising and falling edges. Pins that need raw, low-latency sampling can bypass the debounce per bit.

## Interface
- `WIDTH`, 32: number of pins.
- `SYNC_STAGES`, 2: synchroniser flops per pin; minimum 2.
- `PRESCALE_W`, 16: prescaler width.
- `CNT_W`, 4: per-pin stability counter width.

Clock is `clk_i`. Reset is `rst_i`, which is synchronous and active-high.

- `clk_i` in, 1: system clock.
- `rst_i` in, 1: synchronous active-high reset.
- `pad_i` in, WIDTH: raw asynchronous pad inputs.
- `cfg_enable_i` in, 1: filter enable; must be static-ish, quasi-static config.
- `cfg_prescale_i` in, PRESCALE_W: sample tick period minus 1.
- `cfg_threshold_i` in, CNT_W: number of consecutive differing samples required to accept a change.
- `cfg_bypass_i` in, WIDTH: per-pin debounce bypass.
- `gpio_input_o` out, WIDTH: filtered level; connects to `gpio.gpio_input_i`.
- `rise_o` out, WIDTH: one-cycle pulse on a filtered 0→1 transition.
- `fall_o` out, WIDTH: one-cycle pulse on a filtered 1→0 transition.
- `tick_o` out, 1: sample tick, for observability.

## Operation
- **Synchroniser.** `pad_i` passes through `SYNC_STAGES` flops per bit. The last stage is `sync[i]`.
- **Prescaler.**
  - `pcnt` counts while `cfg_enable_i`=1.
  - When `pcnt >= cfg_prescale_i`, `pcnt` goes to 0 and `tick` is 1 for that cycle. Otherwise `pcnt` increments.
  - The `>=` comparison means a prescale decrease below the current count ticks on the next cycle; the count never runs away.
  - With `cfg_prescale_i`=0, `tick` is 1 every enabled cycle.
  - `cfg_enable_i`=0 holds `pcnt` at 0 and `tick` at 0.
- **Per-pin debounce**, for pins with bypass=0. `thr` = `cfg_threshold_i`, where a value of 0 is treated as 1.
  - `sync == filt`: `cnt` is cleared every cycle, tick or not, so a glitch that returns restarts the count.
  - `sync != filt` and `tick`: if `cnt+1 >= thr`, then `filt <= sync` and `cnt <= 0`. Otherwise `cnt <= cnt+1`.
  - `sync != filt` and no tick: `cnt` holds.
  - `cfg_enable_i`=0: `filt` and `cnt` hold.
- **Bypass pin.** `filt <= sync` every cycle and `cnt` is held at 0. This applies regardless of `cfg_enable_i` and tick.
- **Bypass toggled mid-count.** Entering bypass discards `cnt`. Leaving bypass starts from `cnt`=0 with the current `filt`.
- **Edges.** `rise_o[i] <= ~filt[i] & filt_next[i]` and `fall_o[i] <= filt[i] & ~filt_next[i]`.
  - The pulses are registered, so they are high in the same cycle `gpio_input_o` shows the new level.
  - They are never both high for one pin.
- **Output.** `gpio_input_o = filt`, taken straight from the register, with no combinational path from `pad_i`.

## Timing
- **Reset values:**
  - synchroniser flops 0, `pcnt` 0, all `cnt` 0, `filt` 0;
  - `gpio_input_o`, `rise_o`, `fall_o` and `tick_o` all 0.
  - Reset applies at the `clk_i` edge where `rst_i`=1. Reset mid-count discards all progress.
- **Bypass latency.** A pad change set up before edge 0 appears on `gpio_input_o` after edge `SYNC_STAGES`. With the default, that is the 3rd edge.
- **Debounced latency.** A steady change is accepted on the `thr`-th tick at which `sync != filt`, then seen one cycle later. Worst case is about `SYNC_STAGES + thr*(P+1)` cycles, with P = `cfg_prescale_i`.
- **Tick period.** `tick_o` repeats every P+1 cycles. The first tick comes P+1 cycles after `cfg_enable_i` rises with `pcnt`=0.
- **Glitch rejection.** Any excursion on `sync` that returns before `thr` ticks is fully rejected, and no edge pulse is generated.

## Structure
- **Package `gpio_filter_pkg`:** default widths `GPIO_WIDTH`=32, `GPIO_SYNC_STAGES`=2, `GPIO_PRESCALE_W`=16, `GPIO_CNT_W`=4.
- **Sub-module `gpio_filter_bit`:** synchroniser, `cnt`, `filt` and edge flops for one pin, instantiated WIDTH times by generate.
- **Top level:** the prescaler lives in `gpio_input_filter`, and its `tick` is broadcast to all pins.

## Test plan
- **Bypass path.** Set bypass=FFFF_FFFF and drive `pad_i`=5555_5555 after reset. Required:
  - `gpio_input_o` is 0 for 2 edges, then 5555_5555 after the 3rd;
  - `rise_o`=5555_5555 for exactly that one cycle.
- **Debounce accept.** Set bypass=0, enable=1, P=3, thr=4, and step `pad_i[0]` 0→1 and hold it. Required:
  - `gpio_input_o[0]` rises after the 4th tick, within `SYNC_STAGES`+16 cycles;
  - `rise_o[0]` is a single pulse.
- **Glitch reject.** Same config; `pad_i[0]` is 1 for 10 cycles, then 0. Required: `gpio_input_o[0]` stays 0, no `rise_o` or `fall_o`, `cnt` back to 0.
- **Fall edge and threshold 0.** Set P=0, thr=0, filtered=1, drop `pad[7]`. Required: `gpio_input_o[7]`=0 and `fall_o[7]` pulse 1 cycle after the synchronised value changes.
- **Reset mid-count.** With `cnt`=2 of 4 on pin 3, assert `rst_i` for 1 cycle. Required:
  - all outputs and counters are 0 at the next edge;
  - the pin then needs 4 fresh ticks to accept.
- **Prescale shrink and disable.** At `pcnt`=10, change P from 20 to 5. Required:
  - `tick_o` on the next cycle, then every 6 cycles;
  - clearing enable stops `tick_o` and freezes `gpio_input_o` despite `pad_i` activity.
